// File: rtl/trace_chk_pkg.sv
// Shared types for the lockstep trace checker: error codes, checker states
// and the saturating error-count helper.
package trace_chk_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ERROR = 2'd1,
    DONE  = 2'd2
  } chk_state_e;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/trace_chk_fifo.sv
// Per-channel trace FIFO with a show-ahead head. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module trace_chk_fifo #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              head_valid,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr, rptr;
  logic              do_push, do_pop;

  assign empty      = (wptr == rptr);
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head_valid = !empty;
  assign head       = mem[rptr[AW-1:0]];

  // A full FIFO still accepts a word when its head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/trace_lockstep_checker.sv
// Lockstep trace comparator: buffers each channel's retire stream, compares
// heads against channel 0 and captures the first divergence/overflow/skew.
module trace_lockstep_checker
  import trace_chk_pkg::*;
#(
  parameter int DATA_W      = 36,
  parameter int NCH         = 2,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT     = 1024,
  parameter int STOP_ON_ERR = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic [NCH-1:0]        trace_valid,
  input  logic [NCH*DATA_W-1:0] trace_data,
  input  logic [NCH-1:0]        trap,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [NCH-1:0]        err_chmask,
  output logic [31:0]           err_index,
  output logic [DATA_W-1:0]     err_golden,
  output logic [DATA_W-1:0]     err_actual,
  output logic [31:0]           cmp_count,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  chk_state_e                   state;
  logic [NCH-1:0][DATA_W-1:0]   head;
  logic [NCH-1:0]               hv, empty, full;
  logic [NCH-1:0]               push_en, mismatch, overflow, ev_mask;
  logic [DATA_W-1:0]            mm_actual;
  logic                         active, all_ne, all_empty, pop, skew;
  logic                         to_hit, mm_any, ovf_any, ev;
  err_code_e                    ev_code;
  logic [TW-1:0]                skew_cnt;

  // Continue mode keeps comparing while parked in ERROR.
  assign active    = (state == RUN) || ((state == ERROR) && (STOP_ON_ERR == 0));
  assign push_en   = active ? trace_valid : '0;
  assign all_ne    = &hv;
  assign all_empty = &empty;
  assign pop       = active && all_ne && !clear;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    trace_chk_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .clear     (clear),
      .push      (push_en[k]),
      .pop       (pop),
      .wdata     (trace_data[k*DATA_W +: DATA_W]),
      .head      (head[k]),
      .head_valid(hv[k]),
      .full      (full[k]),
      .empty     (empty[k])
    );
  end

  // Descending scan so the lowest-numbered mismatching channel wins err_actual.
  always_comb begin
    mismatch  = '0;
    mm_actual = '0;
    for (int k = NCH-1; k >= 1; k--) begin
      if (pop && (head[k] != head[0])) begin
        mismatch[k] = 1'b1;
        mm_actual   = head[k];
      end
    end
  end

  assign overflow = push_en & full & {NCH{!pop}};
  assign ovf_any  = |overflow;
  assign mm_any   = |mismatch;
  assign skew     = (|empty) && !all_empty;
  assign to_hit   = active && skew && !pop && (skew_cnt == TW'(TIMEOUT - 1));
  assign ev       = !clear && (ovf_any || mm_any || to_hit);

  always_comb begin
    ev_code = ERR_NONE;
    ev_mask = '0;
    if (ovf_any) begin
      ev_code = ERR_OVERFLOW;
      ev_mask = overflow;
    end else if (mm_any) begin
      ev_code = ERR_MISMATCH;
      ev_mask = mismatch;
    end else if (to_hit) begin
      ev_code = ERR_TIMEOUT;
      ev_mask = empty;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skew_cnt <= '0;
    end else if (clear || !active || pop || !skew || to_hit) begin
      skew_cnt <= '0;
    end else begin
      skew_cnt <= skew_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
    end else if (clear) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (ev)                                        state <= ERROR;
          else if (&trap && all_empty && !(|push_en))    state <= DONE;
        end
        ERROR, DONE: ;
        default: state <= RUN;
      endcase
    end
  end

  assign done = (state == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      error      <= 1'b0;
      err_code   <= '0;
      err_chmask <= '0;
      err_index  <= '0;
      err_golden <= '0;
      err_actual <= '0;
      cmp_count  <= '0;
      err_count  <= '0;
    end else if (clear) begin
      error      <= 1'b0;
      err_code   <= '0;
      err_chmask <= '0;
      err_index  <= '0;
      err_golden <= '0;
      err_actual <= '0;
      cmp_count  <= '0;
      err_count  <= '0;
    end else begin
      if (pop) cmp_count <= cmp_count + 32'd1;
      if (ev) begin
        error     <= 1'b1;
        err_count <= sat_inc(err_count);
      end
      // Only the first event after reset/clear is captured.
      if (ev && !error) begin
        err_code   <= ev_code;
        err_chmask <= ev_mask;
        err_index  <= cmp_count;
        err_golden <= (ev_code == ERR_MISMATCH) ? head[0]   : '0;
        err_actual <= (ev_code == ERR_MISMATCH) ? mm_actual : '0;
      end
    end
  end

endmodule

// File: tb/tb_trace_lockstep_checker.sv
// Scoreboard bench: stimulus queues expected output snapshots; monitors pop
// one entry whenever a DUT's observable outputs change.
module tb_trace_lockstep_checker;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  // DUT A: 2 channels, stop on error, small FIFO and timeout
  logic [1:0]   tv_a, trap_a, mask_a;
  logic [71:0]  td_a;
  logic         clear_a, done_a, error_a;
  logic [1:0]   code_a;
  logic [31:0]  idx_a, cmp_a;
  logic [35:0]  gold_a, act_a;
  logic [15:0]  ecnt_a;

  trace_lockstep_checker #(.DATA_W(36), .NCH(2), .DEPTH(4), .TIMEOUT(8), .STOP_ON_ERR(1)) dut_a (
    .clk(clk), .resetn(resetn), .clear(clear_a), .trace_valid(tv_a), .trace_data(td_a),
    .trap(trap_a), .done(done_a), .error(error_a), .err_code(code_a), .err_chmask(mask_a),
    .err_index(idx_a), .err_golden(gold_a), .err_actual(act_a), .cmp_count(cmp_a),
    .err_count(ecnt_a)
  );

  // DUT B: 3 channels, continue mode
  logic [2:0]   tv_b, trap_b, mask_b;
  logic [107:0] td_b;
  logic         clear_b, done_b, error_b;
  logic [1:0]   code_b;
  logic [31:0]  idx_b, cmp_b;
  logic [35:0]  gold_b, act_b;
  logic [15:0]  ecnt_b;

  trace_lockstep_checker #(.DATA_W(36), .NCH(3), .DEPTH(4), .TIMEOUT(8), .STOP_ON_ERR(0)) dut_b (
    .clk(clk), .resetn(resetn), .clear(clear_b), .trace_valid(tv_b), .trace_data(td_b),
    .trap(trap_b), .done(done_b), .error(error_b), .err_code(code_b), .err_chmask(mask_b),
    .err_index(idx_b), .err_golden(gold_b), .err_actual(act_b), .cmp_count(cmp_b),
    .err_count(ecnt_b)
  );

  typedef struct packed {
    logic [31:0] cmp;
    logic        err;
    logic [1:0]  code;
    logic [2:0]  mask;
    logic [31:0] idx;
    logic [35:0] gold;
    logic [35:0] act;
    logic [15:0] ecnt;
    logic        done;
  } obs_t;

  typedef struct {
    string name;
    int    cyc;
    obs_t  o;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  obs_t cur_a, prev_a, cur_b, prev_b;
  logic skip_a, skip_b;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic exp_t mk(input string n, input int c, input logic [31:0] cm, input logic er,
                              input logic [1:0] cd, input logic [2:0] m, input logic [31:0] ix,
                              input logic [35:0] g, input logic [35:0] a, input logic [15:0] ec,
                              input logic dn);
    exp_t e;
    e.name = n; e.cyc = c;
    e.o = '{cmp:cm, err:er, code:cd, mask:m, idx:ix, gold:g, act:a, ecnt:ec, done:dn};
    return e;
  endfunction

  function automatic exp_t ok(input string n, input logic [31:0] cm);
    return mk(n, -1, cm, 1'b0, 2'd0, 3'd0, 32'd0, 36'd0, 36'd0, 16'd0, 1'b0);
  endfunction

  task automatic check_obs(input string t, input obs_t g, input exp_t e);
    chk({t, ".", e.name, ".cmp"},   64'(g.cmp),  64'(e.o.cmp));
    chk({t, ".", e.name, ".error"}, 64'(g.err),  64'(e.o.err));
    chk({t, ".", e.name, ".code"},  64'(g.code), 64'(e.o.code));
    chk({t, ".", e.name, ".mask"},  64'(g.mask), 64'(e.o.mask));
    chk({t, ".", e.name, ".index"}, 64'(g.idx),  64'(e.o.idx));
    chk({t, ".", e.name, ".gold"},  64'(g.gold), 64'(e.o.gold));
    chk({t, ".", e.name, ".act"},   64'(g.act),  64'(e.o.act));
    chk({t, ".", e.name, ".ecnt"},  64'(g.ecnt), 64'(e.o.ecnt));
    chk({t, ".", e.name, ".done"},  64'(g.done), 64'(e.o.done));
    if (e.cyc >= 0) chk({t, ".", e.name, ".cycle"}, 64'(cyc), 64'(e.cyc));
  endtask

  always @(negedge clk) begin
    cur_a = '{cmp:cmp_a, err:error_a, code:code_a, mask:{1'b0, mask_a}, idx:idx_a,
              gold:gold_a, act:act_a, ecnt:ecnt_a, done:done_a};
    if (skip_a) prev_a = cur_a;
    else if (cur_a != prev_a) begin
      prev_a = cur_a;
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a.unexpected got cmp=%0d err=%0d code=%0d want no change", cmp_a, error_a, code_a);
      end else check_obs("a", cur_a, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    cur_b = '{cmp:cmp_b, err:error_b, code:code_b, mask:mask_b, idx:idx_b,
              gold:gold_b, act:act_b, ecnt:ecnt_b, done:done_b};
    if (skip_b) prev_b = cur_b;
    else if (cur_b != prev_b) begin
      prev_b = cur_b;
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b.unexpected got cmp=%0d err=%0d ecnt=%0d want no change", cmp_b, error_b, ecnt_b);
      end else check_obs("b", cur_b, qb.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] v, input logic [35:0] d0, input logic [35:0] d1);
    tv_a = v; td_a = {d1, d0};
    step();
    tv_a = '0;
  endtask

  task automatic drive_b(input logic [2:0] v, input logic [35:0] d0, input logic [35:0] d1,
                         input logic [35:0] d2);
    tv_b = v; td_b = {d2, d1, d0};
    step();
    tv_b = '0;
  endtask

  task automatic drain(input bit which_b, input string nm);
    int n;
    n = 0;
    while ((which_b ? qb.size() : qa.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    total++;
    if ((which_b ? qb.size() : qa.size()) != 0) begin
      bad++;
      $display("FAIL %s.pending got=%0d want=0 outstanding events", nm, which_b ? qb.size() : qa.size());
      if (which_b) qb.delete(); else qa.delete();
    end
  endtask

  task automatic zero_a(input string nm);
    chk({nm, ".a.cmp"}, 64'(cmp_a), 64'd0);
    chk({nm, ".a.error"}, 64'(error_a), 64'd0);
    chk({nm, ".a.code"}, 64'(code_a), 64'd0);
    chk({nm, ".a.mask"}, 64'(mask_a), 64'd0);
    chk({nm, ".a.index"}, 64'(idx_a), 64'd0);
    chk({nm, ".a.gold"}, 64'(gold_a), 64'd0);
    chk({nm, ".a.act"}, 64'(act_a), 64'd0);
    chk({nm, ".a.ecnt"}, 64'(ecnt_a), 64'd0);
    chk({nm, ".a.done"}, 64'(done_a), 64'd0);
  endtask

  task automatic clear_dut_a(input string nm);
    skip_a = 1'b1;
    clear_a = 1'b1;
    step();
    clear_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    skip_a = 1'b0;
    zero_a(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] w0 [7];
    logic [35:0] w1 [7];
    int e;

    resetn = 1'b0; skip_a = 1'b1; skip_b = 1'b1;
    clear_a = 1'b0; tv_a = '0; td_a = '0; trap_a = '0;
    clear_b = 1'b0; tv_b = '0; td_b = '0; trap_b = '0;
    repeat (2) @(negedge clk);
    zero_a("reset");
    chk("reset.b.cmp", 64'(cmp_b), 64'd0);
    chk("reset.b.error", 64'(error_b), 64'd0);
    chk("reset.b.ecnt", 64'(ecnt_b), 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    skip_a = 1'b0; skip_b = 1'b0;

    // identical streams with 3 cycles of skew, then both trap
    qa.push_back(ok("ident1", 32'd1));
    qa.push_back(ok("ident2", 32'd2));
    qa.push_back(mk("ident_done", -1, 32'd2, 1'b0, 2'd0, 3'd0, 32'd0, 36'd0, 36'd0, 16'd0, 1'b1));
    drive_a(2'b01, 36'h0_0000_0013, 36'h0);
    drive_a(2'b01, 36'h1, 36'h0);
    step();
    drive_a(2'b10, 36'h0, 36'h0_0000_0013);
    drive_a(2'b10, 36'h0, 36'h1);
    repeat (3) step();
    trap_a = 2'b11;
    drain(1'b0, "ident");
    trap_a = 2'b00;
    clear_dut_a("clr1");

    // mismatch on the 5th word, later words ignored
    w0 = '{36'h11, 36'h22, 36'h33, 36'h44, 36'hA5, 36'h66, 36'h77};
    w1 = '{36'h11, 36'h22, 36'h33, 36'h44, 36'hA4, 36'h66, 36'h77};
    qa.push_back(ok("mm1", 32'd1));
    qa.push_back(ok("mm2", 32'd2));
    qa.push_back(ok("mm3", 32'd3));
    qa.push_back(ok("mm4", 32'd4));
    qa.push_back(mk("mm_err", -1, 32'd5, 1'b1, 2'd1, 3'b010, 32'd4, 36'hA5, 36'hA4, 16'd1, 1'b0));
    for (int i = 0; i < 7; i++) drive_a(2'b11, w0[i], w1[i]);
    drain(1'b0, "mismatch");
    clear_dut_a("clr2");

    // overflow: channel 0 pushes 5 words into a depth-4 FIFO
    for (int i = 1; i <= 4; i++) drive_a(2'b01, 36'(i), 36'h0);
    drive_a(2'b01, 36'h5, 36'h0);
    qa.push_back(mk("ovf", cyc, 32'd0, 1'b1, 2'd2, 3'b001, 32'd0, 36'd0, 36'd0, 16'd1, 1'b0));
    drain(1'b0, "overflow");
    clear_dut_a("clr3");

    // timeout: channel 1 silent, flagged 8 cycles after the push edge
    drive_a(2'b01, 36'h77, 36'h0);
    e = cyc;
    qa.push_back(mk("tmo", e + 8, 32'd0, 1'b1, 2'd3, 3'b010, 32'd0, 36'd0, 36'd0, 16'd1, 1'b0));
    drain(1'b0, "timeout");
    clear_dut_a("clr4");

    // reset mid-stream with channel 0 words buffered
    qa.push_back(ok("pre1", 32'd1));
    qa.push_back(ok("pre2", 32'd2));
    drive_a(2'b11, 36'h1, 36'h1);
    drive_a(2'b11, 36'h2, 36'h2);
    drain(1'b0, "pre_rst");
    drive_a(2'b01, 36'h5, 36'h0);
    drive_a(2'b01, 36'h6, 36'h0);
    skip_a = 1'b1; skip_b = 1'b1;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    zero_a("midrst");
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    skip_a = 1'b0; skip_b = 1'b0;
    qa.push_back(ok("post_rst1", 32'd1));
    qa.push_back(ok("post_rst2", 32'd2));
    drive_a(2'b11, 36'h9, 36'h9);
    drive_a(2'b11, 36'hA, 36'hA);
    drain(1'b0, "post_rst");

    // clear mid-stream with channel 0 words buffered
    drive_a(2'b01, 36'h5, 36'h0);
    drive_a(2'b01, 36'h6, 36'h0);
    clear_dut_a("midclr");
    qa.push_back(ok("post_clr1", 32'd1));
    qa.push_back(ok("post_clr2", 32'd2));
    qa.push_back(mk("post_clr_done", -1, 32'd2, 1'b0, 2'd0, 3'd0, 32'd0, 36'd0, 36'd0, 16'd0, 1'b1));
    drive_a(2'b11, 36'hC, 36'hC);
    drive_a(2'b11, 36'hD, 36'hD);
    step();
    trap_a = 2'b11;
    drain(1'b0, "post_clr");

    // continue mode: two separate mismatches on channel 2
    qb.push_back(ok("cont1", 32'd1));
    qb.push_back(mk("cont2", -1, 32'd2, 1'b1, 2'd1, 3'b100, 32'd1, 36'hB0, 36'hB1, 16'd1, 1'b0));
    qb.push_back(mk("cont3", -1, 32'd3, 1'b1, 2'd1, 3'b100, 32'd1, 36'hB0, 36'hB1, 16'd1, 1'b0));
    qb.push_back(mk("cont4", -1, 32'd4, 1'b1, 2'd1, 3'b100, 32'd1, 36'hB0, 36'hB1, 16'd2, 1'b0));
    qb.push_back(mk("cont5", -1, 32'd5, 1'b1, 2'd1, 3'b100, 32'd1, 36'hB0, 36'hB1, 16'd2, 1'b0));
    drive_b(3'b111, 36'h10, 36'h10, 36'h10);
    drive_b(3'b111, 36'hB0, 36'hB0, 36'hB1);
    drive_b(3'b111, 36'h30, 36'h30, 36'h30);
    drive_b(3'b111, 36'hD1, 36'hD1, 36'hD0);
    drive_b(3'b111, 36'h50, 36'h50, 36'h50);
    repeat (2) step();
    trap_b = 3'b111;
    drain(1'b1, "continue");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
